// File: rtl/issue_buffer_m2.sv
// In-order issue buffer: a DEPTH-entry FIFO whose head is checked against a
// register scoreboard, with writeback forwarding and a fence-drain FSM.
// Optional stall counter enabled by defining ISSUE_PERF_CNT_EN.
module issue_buffer_m2 #(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [11:0]             in_inst,
  input  logic [14:0]             in_pc,
  input  logic [2:0]              in_fu,
  input  logic                    in_rs1_dep,
  input  logic                    in_rs2_dep,
  input  logic                    in_wr,
  input  logic                    in_fence,
  output logic [3:0]              rf_rs1_addr,
  output logic [3:0]              rf_rs2_addr,
  input  logic [15:0]             rf_rs1_data,
  input  logic [15:0]             rf_rs2_data,
  input  logic [WB_PORTS-1:0]     wb_en,
  input  logic [4*WB_PORTS-1:0]   wb_addr,
  input  logic [16*WB_PORTS-1:0]  wb_data,
  input  logic [4:0]              fu_ready,
  input  logic                    exe_idle,
  output logic                    issue_valid,
  output logic [2:0]              issue_fu,
  output logic [11:0]             issue_inst,
  output logic [14:0]             issue_pc,
  output logic [3:0]              issue_dest,
  output logic [15:0]             issue_data1,
  output logic [15:0]             issue_data2,
  output logic [15:0]             perf_stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StDrain} fence_state_e;

  // Payload storage; only pointers and count need reset.
  logic [11:0] inst_q  [DEPTH];
  logic [14:0] pc_q    [DEPTH];
  logic [2:0]  fu_q    [DEPTH];
  logic        dep1_q  [DEPTH];
  logic        dep2_q  [DEPTH];
  logic        wr_q    [DEPTH];
  logic        fence_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      sb_q, sb_d;
  fence_state_e     state_q;

  logic        push, pop, head_valid;
  logic [11:0] head_inst;
  logic [2:0]  head_fu;
  logic        head_dep1, head_dep2, head_wr, head_fence;
  logic [3:0]  head_rs1, head_rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [15:0] fwd1_data, fwd2_data;
  logic        busy1, busy2, hazard, fu_ok, fence_open;
  logic [7:0]  fu_ready_ext;

  assign head_valid = (count_q != '0);
  assign head_inst  = inst_q[rd_ptr_q];
  assign head_fu    = fu_q[rd_ptr_q];
  assign head_dep1  = dep1_q[rd_ptr_q];
  assign head_dep2  = dep2_q[rd_ptr_q];
  assign head_wr    = wr_q[rd_ptr_q];
  assign head_fence = fence_q[rd_ptr_q];
  assign head_rs1   = head_inst[7:4];
  assign head_rs2   = head_inst[3:0];

  assign rf_rs1_addr = head_rs1;
  assign rf_rs2_addr = head_rs2;

  // Full check ignores a same-cycle pop so that ready never depends on issue.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = issue_valid;

  // Forwarding: scan from the highest port down so the lowest index wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (wb_en[p] && (wb_addr[p*4 +: 4] == head_rs1) && (head_rs1 != 4'd0)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = wb_data[p*16 +: 16];
      end
      if (wb_en[p] && (wb_addr[p*4 +: 4] == head_rs2) && (head_rs2 != 4'd0)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = wb_data[p*16 +: 16];
      end
    end
  end

  // rs1 doubles as the destination, so a busy rs1 also blocks writers (WAW).
  assign busy1  = sb_q[head_rs1] && !fwd1_hit;
  assign busy2  = sb_q[head_rs2] && !fwd2_hit;
  assign hazard = (busy1 && (head_dep1 || head_wr)) || (busy2 && head_dep2);

  // Unit indices 5..7 map onto zero-padded bits and therefore never issue.
  assign fu_ready_ext = {3'b000, fu_ready};
  assign fu_ok        = fu_ready_ext[head_fu];

  assign fence_open = !head_fence || ((state_q == StDrain) && exe_idle && (sb_q == 16'h0000));

  assign issue_valid = head_valid && !hazard && fu_ok && !flush && fence_open;
  assign issue_fu    = head_fu;
  assign issue_inst  = head_inst;
  assign issue_pc    = pc_q[rd_ptr_q];
  assign issue_dest  = head_rs1;
  assign issue_data1 = fwd1_hit ? fwd1_data : rf_rs1_data;
  assign issue_data2 = fwd2_hit ? fwd2_data : rf_rs2_data;

  // Scoreboard next state: writebacks clear, issue sets, set wins on collision.
  always_comb begin
    sb_d = sb_q;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_en[p]) sb_d[wb_addr[p*4 +: 4]] = 1'b0;
    end
    if (issue_valid && head_wr && (head_rs1 != 4'd0)) sb_d[head_rs1] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Scoreboard register; survives flush since in-flight writers still complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  // Payload write on push.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q]  <= in_inst;
      pc_q[wr_ptr_q]    <= in_pc;
      fu_q[wr_ptr_q]    <= in_fu;
      dep1_q[wr_ptr_q]  <= in_rs1_dep;
      dep2_q[wr_ptr_q]  <= in_rs2_dep;
      wr_q[wr_ptr_q]    <= in_wr;
      fence_q[wr_ptr_q] <= in_fence;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Fence FSM: a fence at head first drains, then issues once all is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:  if (head_valid && head_fence) state_q <= StDrain;
        StDrain: if (issue_valid) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] perf_q;

  // Saturating count of stalled cycles (hazard at head or fence draining).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (((head_valid && hazard) || (state_q == StDrain)) && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_buffer_m2.sv
// Randomized and directed bench for issue_buffer_m2 against a queue-based model.
module tb_issue_buffer_m2;

  localparam int DEPTH = 4;
  localparam int WB    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, in_valid, in_ready;
  logic [11:0]   in_inst;
  logic [14:0]   in_pc;
  logic [2:0]    in_fu;
  logic          in_rs1_dep, in_rs2_dep, in_wr, in_fence;
  logic [3:0]    rf_rs1_addr, rf_rs2_addr;
  logic [15:0]   rf_rs1_data, rf_rs2_data;
  logic [WB-1:0] wb_en;
  logic [4*WB-1:0]  wb_addr;
  logic [16*WB-1:0] wb_data;
  logic [4:0]    fu_ready;
  logic          exe_idle, issue_valid;
  logic [2:0]    issue_fu;
  logic [11:0]   issue_inst;
  logic [14:0]   issue_pc;
  logic [3:0]    issue_dest;
  logic [15:0]   issue_data1, issue_data2, perf_stall_cnt;

  logic [15:0] rf_mem [16];
  assign rf_rs1_data = rf_mem[rf_rs1_addr];
  assign rf_rs2_data = rf_mem[rf_rs2_addr];

  issue_buffer_m2 #(.DEPTH(DEPTH), .WB_PORTS(WB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_fu(in_fu), .in_rs1_dep(in_rs1_dep), .in_rs2_dep(in_rs2_dep), .in_wr(in_wr),
    .in_fence(in_fence), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .fu_ready(fu_ready), .exe_idle(exe_idle),
    .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_inst(issue_inst),
    .issue_pc(issue_pc), .issue_dest(issue_dest), .issue_data1(issue_data1),
    .issue_data2(issue_data2), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] inst;
    logic [14:0] pc;
    logic [2:0]  fu;
    logic        d1, d2, wr, fence;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic [15:0] sb;
  bit          drain;
  int          perf;
  bit          acc;

  int n_vec = 0;
  int n_err = 0;
  int pc_seq = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    return {f, a, b};
  endfunction

  function automatic ent_t ent(input logic [11:0] inst, input logic [2:0] fu,
                               input logic d1, input logic d2, input logic wr, input logic fence);
    ent_t e;
    e.inst = inst; e.fu = fu; e.d1 = d1; e.d2 = d2; e.wr = wr; e.fence = fence;
    e.pc = 15'(pc_seq * 3 + 100);
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    sb = '0;
    drain = 0;
    perf = 0;
  endtask

  // One clock: inputs already applied at negedge; check, then advance model.
  task automatic cycle();
    bit          hv, f1, f2, busy1, busy2, haz, fu_ok, gate, exp_iv, exp_rdy;
    ent_t        h;
    logic [3:0]  r1, r2;
    logic [15:0] d1, d2, nsb;
    ent_t        e;
    #1;
    hv = (q.size() != 0);
    h  = hv ? q[0] : '0;
    r1 = h.inst[7:4];
    r2 = h.inst[3:0];
    d1 = rf_mem[r1];
    d2 = rf_mem[r2];
    f1 = 0;
    f2 = 0;
    for (int p = 0; p < WB; p++) begin
      if (!f1 && wb_en[p] && wb_addr[p*4 +: 4] == r1 && r1 != 0) begin
        f1 = 1; d1 = wb_data[p*16 +: 16];
      end
      if (!f2 && wb_en[p] && wb_addr[p*4 +: 4] == r2 && r2 != 0) begin
        f2 = 1; d2 = wb_data[p*16 +: 16];
      end
    end
    busy1   = sb[r1] && !f1;
    busy2   = sb[r2] && !f2;
    haz     = (busy1 && (h.d1 || h.wr)) || (busy2 && h.d2);
    fu_ok   = (h.fu < 5) && fu_ready[h.fu];
    gate    = !h.fence || (drain && exe_idle && sb == 0);
    exp_iv  = hv && !haz && fu_ok && !flush && gate;
    exp_rdy = (q.size() < DEPTH);
    acc     = in_valid && exp_rdy && !flush;

    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("issue_valid", 32'(issue_valid), 32'(exp_iv));
    check_eq("perf_stall_cnt", 32'(perf_stall_cnt), 32'(perf));
    if (hv) begin
      check_eq("rf_rs1_addr", 32'(rf_rs1_addr), 32'(r1));
      check_eq("rf_rs2_addr", 32'(rf_rs2_addr), 32'(r2));
    end
    if (exp_iv) begin
      check_eq("issue_inst", 32'(issue_inst), 32'(h.inst));
      check_eq("issue_pc", 32'(issue_pc), 32'(h.pc));
      check_eq("issue_fu", 32'(issue_fu), 32'(h.fu));
      check_eq("issue_dest", 32'(issue_dest), 32'(r1));
      check_eq("issue_data1", 32'(issue_data1), 32'(d1));
      check_eq("issue_data2", 32'(issue_data2), 32'(d2));
    end

    @(posedge clk);
    nsb = sb;
    for (int p = 0; p < WB; p++) if (wb_en[p]) nsb[wb_addr[p*4 +: 4]] = 1'b0;
    if (exp_iv && h.wr && r1 != 0) nsb[r1] = 1'b1;
    nsb[0] = 1'b0;
`ifdef ISSUE_PERF_CNT_EN
    if (((hv && haz) || drain) && perf < 65535) perf++;
`endif
    if (flush) begin
      q.delete();
      drain = 0;
    end else begin
      if (!drain && hv && h.fence) drain = 1;
      else if (drain && exp_iv) drain = 0;
      if (exp_iv) void'(q.pop_front());
      if (acc) begin
        e.inst = in_inst; e.pc = in_pc; e.fu = in_fu; e.d1 = in_rs1_dep;
        e.d2 = in_rs2_dep; e.wr = in_wr; e.fence = in_fence;
        q.push_back(e);
      end
    end
    sb = nsb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_wait(input ent_t e, input int max);
    bit done;
    done = 0;
    in_valid = 1; in_inst = e.inst; in_pc = e.pc; in_fu = e.fu;
    in_rs1_dep = e.d1; in_rs2_dep = e.d2; in_wr = e.wr; in_fence = e.fence;
    pc_seq++;
    for (int i = 0; i < max && !done; i++) begin
      cycle();
      done = acc;
    end
    in_valid = 0;
    if (!done) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_wb(input logic [WB-1:0] en, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [15:0] x0, input logic [15:0] x1);
    wb_en = en;
    wb_addr = {a1, a0};
    wb_data = {x1, x0};
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
    rst_n = 0; flush = 0; in_valid = 0; in_inst = '0; in_pc = '0; in_fu = '0;
    in_rs1_dep = 0; in_rs2_dep = 0; in_wr = 0; in_fence = 0;
    wb_en = '0; wb_addr = '0; wb_data = '0; fu_ready = 5'h1f; exe_idle = 1;
    model_reset();
    #1;
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_issue_valid", 32'(issue_valid), 32'd0);
    check_eq("reset_perf", 32'(perf_stall_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(2);

    // Writer r3, then a consumer of r3 via rs2 held until forwarded writeback.
    push_wait(ent(mk(4'h1, 4'd3, 4'd0), 3'd0, 0, 0, 1, 0), 4);
    idle(1);
    push_wait(ent(mk(4'h2, 4'd1, 4'd3), 3'd1, 0, 1, 0, 0), 4);
    idle(3);
    set_wb(2'b01, 4'd3, 4'd0, 16'h1234, 16'h0);
    #1;
    check_eq("fwd_issue_valid", 32'(issue_valid), 32'd1);
    check_eq("fwd_data2", 32'(issue_data2), 32'h1234);
    cycle();
    set_wb(2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    idle(1);

    // Both ports write r2: port 0 has priority.
    push_wait(ent(mk(4'h3, 4'd2, 4'd4), 3'd2, 1, 0, 0, 0), 4);
    set_wb(2'b11, 4'd2, 4'd2, 16'hAAAA, 16'hBBBB);
    #1;
    check_eq("prio_data1", 32'(issue_data1), 32'hAAAA);
    cycle();
    set_wb(2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    idle(1);

    // Fence waits in drain while r5 is busy, issues the cycle after writeback.
    push_wait(ent(mk(4'h4, 4'd5, 4'd0), 3'd0, 0, 0, 1, 0), 4);
    idle(1);
    push_wait(ent(mk(4'h0, 4'd0, 4'd0), 3'd1, 0, 0, 0, 1), 4);
    idle(4);
    set_wb(2'b01, 4'd5, 4'd0, 16'h5555, 16'h0);
    cycle();
    set_wb(2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    #1;
    check_eq("fence_issue", 32'(issue_valid), 32'd1);
    cycle();
    idle(2);

    // Flush with three buffered entries while r7 is busy.
    push_wait(ent(mk(4'h5, 4'd7, 4'd0), 3'd0, 0, 0, 1, 0), 4);
    idle(1);
    fu_ready = 5'h00;
    for (int i = 0; i < 3; i++) push_wait(ent(mk(4'h6, 4'(i + 8), 4'd1), 3'd3, 0, 0, 0, 0), 4);
    flush = 1;
    fu_ready = 5'h1f;
    #1;
    check_eq("flush_issue_valid", 32'(issue_valid), 32'd0);
    cycle();
    flush = 0;
    idle(1);
    push_wait(ent(mk(4'h7, 4'd7, 4'd1), 3'd4, 1, 0, 0, 0), 4);
    idle(3);
    set_wb(2'b10, 4'd0, 4'd7, 16'h0, 16'h7777);
    cycle();
    set_wb(2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    idle(1);

    // Fill to DEPTH with no unit ready; the fifth waits for one issue.
    fu_ready = 5'h00;
    for (int i = 0; i < 4; i++) push_wait(ent(mk(4'h8, 4'(i), 4'(i + 1)), 3'd1, 0, 0, 0, 0), 4);
    in_valid = 1; in_inst = mk(4'h9, 4'd9, 4'd9); in_pc = 15'h7abc; in_fu = 3'd1;
    cycle();
    fu_ready = 5'h1f;
    push_wait(ent(mk(4'h9, 4'd9, 4'd9), 3'd1, 0, 0, 0, 0), 4);
    idle(8);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_inst    = 12'($urandom);
      in_pc      = 15'($urandom);
      in_fu      = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_rs1_dep = 1'($urandom);
      in_rs2_dep = 1'($urandom);
      in_wr      = ($urandom_range(0, 2) == 0);
      in_fence   = ($urandom_range(0, 15) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      fu_ready   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1f;
      exe_idle   = ($urandom_range(0, 4) != 0);
      wb_en      = 2'($urandom);
      wb_addr    = 8'($urandom);
      wb_data    = 32'($urandom);
      cycle();
    end
    in_valid = 0; flush = 0; wb_en = '0; fu_ready = 5'h1f; exe_idle = 1;
    idle(1);

    // Asynchronous reset with a full buffer.
    flush = 1;
    cycle();
    flush = 0;
    fu_ready = 5'h00;
    for (int i = 0; i < 4; i++) push_wait(ent(mk(4'hA, 4'(i + 1), 4'd0), 3'd0, 0, 0, 0, 0), 4);
    #3;
    rst_n = 0;
    #1;
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_issue_valid", 32'(issue_valid), 32'd0);
    check_eq("arst_perf", 32'(perf_stall_cnt), 32'd0);
    model_reset();
    fu_ready = 5'h1f;
    @(negedge clk);
    rst_n = 1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_buffer_m2.md
ISSUE_BUFFER_M2 -- requirements
Module: issue_buffer_m2

Interface
REQ-001 SHALL have parameter DEPTH, default 4, issue-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter WB_PORTS, default 2, number of writeback forwarding ports.
REQ-003 SHALL have ports clk input 1 (single clock, rising edge) and rst_n input 1 (reset, asynchronous, active-low).
REQ-004 SHALL have flush input 1 (discard all buffered instructions).
REQ-005 SHALL have in_valid input 1, in_ready output 1, in_inst input 12, in_pc input 15, in_fu input 3 (unit index 0..4), in_rs1_dep input 1, in_rs2_dep input 1, in_wr input 1, in_fence input 1.
REQ-006 SHALL have rf_rs1_addr output 4, rf_rs2_addr output 4, rf_rs1_data input 16, rf_rs2_data input 16 (combinational regfile read of head entry).
REQ-007 SHALL have wb_en input WB_PORTS, wb_addr input 4*WB_PORTS, wb_data input 16*WB_PORTS.
REQ-008 SHALL have fu_ready input 5, exe_idle input 1.
REQ-009 SHALL have issue_valid output 1, issue_fu output 3, issue_inst output 12, issue_pc output 15, issue_dest output 4, issue_data1 output 16, issue_data2 output 16, perf_stall_cnt output 16.

Function
REQ-010 SHALL decode fields as func4=inst[11:8], rs1/rd=inst[7:4], rs2=inst[3:0].
REQ-011 SHALL store pushes (in_valid && in_ready) in a DEPTH-entry FIFO; pointers wrap modulo DEPTH; count width clog2(DEPTH+1).
REQ-012 SHALL drive in_ready = (count < DEPTH); a push and pop in the same cycle at full is not accepted.
REQ-013 SHALL present only the head entry for issue; minimum latency push-to-issue_valid is 1 cycle; in-order issue only.
REQ-014 SHALL hold a 16-bit scoreboard; bit 0 is never set.
REQ-015 SHALL forward wb_data of the lowest-indexed port with wb_en && wb_addr==reg && reg!=0; forwarded registers count as not busy.
REQ-016 SHALL flag hazard when rs1 busy && (rs1_dep || wr) or rs2 busy && rs2_dep, after forwarding.
REQ-017 SHALL assert issue_valid when head valid, no hazard, fu_ready[fu]=1, no flush, fence gate open; pop on issue_valid.
REQ-018 SHALL drive issue_data1/2 from forwarded-or-regfile rs1/rs2 data; issue_dest = rs1.
REQ-019 SHALL set scoreboard bit rd on issue when wr && rd!=0 and clear bits on each wb_en port; same-cycle set and clear of one bit: set wins.
REQ-020 SHALL run fence FSM IDLE/DRAIN: IDLE->DRAIN when fence at head; fence issues from DRAIN only when exe_idle && scoreboard==0; DRAIN->IDLE on that issue or flush.
REQ-021 SHALL on flush: empty FIFO (count=0, pointers=0), FSM->IDLE, suppress that cycle's issue and push; scoreboard retained.
REQ-022 SHALL treat in_fu>4 as fu_ready=0 (never issues until flush).

Reset
REQ-023 SHALL on rst_n low asynchronously clear count, pointers, scoreboard, perf counter and set FSM=IDLE.
REQ-024 SHALL hold in_ready=1, issue_valid=0, perf_stall_cnt=0 during and after reset until first push.

Configuration
REQ-025 SHALL with ISSUE_PERF_CNT_EN defined count cycles with valid head and hazard or FSM=DRAIN, saturating at 16'hFFFF.
REQ-026 SHALL without ISSUE_PERF_CNT_EN tie perf_stall_cnt to 0 and omit the counter.

Verification
REQ-027 SHALL cover push r3 writer (wr=1) then dependent rs2=3 -> second held until wb_en[0], wb_addr=3, wb_data=16'h1234; issues that cycle with data2=16'h1234.
REQ-028 SHALL cover DEPTH=4, fu_ready=0, 5 pushes -> in_ready=0 after fourth; fifth accepted only after one issue; order preserved across pointer wrap.
REQ-029 SHALL cover fence at head with scoreboard bit 5 set, exe_idle=1 -> DRAIN held until r5 writeback, fence issues next evaluation, FSM IDLE.
REQ-030 SHALL cover flush with 3 buffered entries and bit 7 busy -> count=0, issue_valid=0 that cycle, bit 7 still busy.
REQ-031 SHALL cover wb ports 0 and 1 both addr=2 with 16'hAAAA/16'hBBBB -> issue_data1=16'hAAAA.
REQ-032 SHALL cover rst_n low mid-operation with full buffer -> in_ready=1, issue_valid=0, perf_stall_cnt=0 immediately.
